// File: rtl/hub_xfer.sv
// hub_xfer: single-requester hub transfer engine (byte/word/long read and write over a slotted hub bus).
// Optional build macro HUB_XFER_ALIGN_CHK_EN rejects misaligned word/long requests with err.
module hub_xfer (
    input  logic        clk_cog,
    input  logic        reset,
    input  logic        ena_bus,
    input  logic        slot_go,
    input  logic        req,
    input  logic        req_we,
    input  logic [1:0]  req_sz,
    input  logic [15:0] req_adr,
    input  logic [31:0] req_wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd,
    output logic        err,
    output logic        mem_w,
    output logic [3:0]  mem_wb,
    output logic [13:0] mem_a,
    output logic [31:0] mem_d,
    input  logic [31:0] mem_q
);

    localparam int unsigned DW  = 32;
    localparam int unsigned LW  = 14;
    localparam int unsigned WBW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic           accept_c;
    logic           we_q;
    logic [1:0]     sz_q;
    logic [1:0]     off_q;
    logic [WBW-1:0] wb_c;
    logic [DW-1:0]  d_c;
    logic [DW-1:0]  rd_c;

`ifdef HUB_XFER_ALIGN_CHK_EN
    logic           misalign_c;
    logic           err_q;

    // Word needs an even address, long needs a long-aligned address.
    always_comb begin
        misalign_c = 1'b0;
        case (req_sz)
            2'b00:   misalign_c = 1'b0;
            2'b01:   misalign_c = req_adr[0];
            default: misalign_c = (req_adr[1:0] != 2'b00);
        endcase
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_cog) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; req only sampled in IDLE.
    always_comb begin
        state_nx = state;
        accept_c = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept_c = 1'b1;
`ifdef HUB_XFER_ALIGN_CHK_EN
                    state_nx = misalign_c ? DONE : WAIT;
`else
                    state_nx = WAIT;
`endif
                end
            end
            WAIT: begin
                if (ena_bus && slot_go) begin
                    state_nx = CAP;
                end
            end
            CAP:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Byte-lane enables and replicated write data for the incoming request.
    always_comb begin
        wb_c = 4'b1111;
        d_c  = req_wd;
        case (req_sz)
            2'b00: begin
                wb_c = WBW'(4'b0001 << req_adr[1:0]);
                d_c  = {4{req_wd[7:0]}};
            end
            2'b01: begin
                wb_c = req_adr[1] ? 4'b1100 : 4'b0011;
                d_c  = {2{req_wd[15:0]}};
            end
            default: begin
                wb_c = 4'b1111;
                d_c  = req_wd;
            end
        endcase
    end

    // Read data lane extraction from the hub's registered read word.
    always_comb begin
        rd_c = mem_q;
        case (sz_q)
            2'b00:   rd_c = DW'(mem_q[{off_q, 3'b000} +: 8]);
            2'b01:   rd_c = DW'(mem_q[{off_q[1], 4'b0000} +: 16]);
            default: rd_c = mem_q;
        endcase
        if (we_q) begin
            rd_c = '0;
        end
    end

    // Write strobe only while waiting on our slot; reset suppresses it immediately.
    assign mem_w = (state == WAIT) & we_q & slot_go & ~reset;

    // Request latch and hub-side address/lane/data registers.
    always_ff @(posedge clk_cog) begin
        if (reset) begin
            we_q   <= 1'b0;
            sz_q   <= 2'b00;
            off_q  <= 2'b00;
            mem_a  <= '0;
            mem_wb <= '0;
            mem_d  <= '0;
        end else if (accept_c) begin
            we_q   <= req_we;
            sz_q   <= req_sz;
            off_q  <= req_adr[1:0];
            mem_a  <= LW'(req_adr[15:2]);
            mem_wb <= wb_c;
            mem_d  <= d_c;
        end
    end

    // Status outputs follow the next state so they line up with the state register.
    always_ff @(posedge clk_cog) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx != IDLE);
            done <= (state_nx == DONE);
        end
    end

    // Result register; holds from one DONE to the next.
    always_ff @(posedge clk_cog) begin
        if (reset) begin
            rd <= '0;
        end else if (state == CAP) begin
            rd <= rd_c;
`ifdef HUB_XFER_ALIGN_CHK_EN
        end else if (accept_c && misalign_c) begin
            rd <= '0;
`endif
        end
    end

`ifdef HUB_XFER_ALIGN_CHK_EN
    always_ff @(posedge clk_cog) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state == CAP) begin
            err_q <= 1'b0;
        end else if (accept_c && misalign_c) begin
            err_q <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/hub_xfer.md
HUB_XFER -- requirements
Module: hub_xfer

Interface
REQ-001 SHALL expose clk_cog  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL expose reset  in  1  synchronous, active-high reset.
REQ-003 SHALL expose ena_bus  in  1  hub bus clock-enable qualifier.
REQ-004 SHALL expose slot_go  in  1  this requester owns the hub slot on the current ena_bus cycle.
REQ-005 SHALL expose req  in  1  request strobe, sampled only in IDLE.
REQ-006 SHALL expose req_we  in  1  1 = write, 0 = read.
REQ-007 SHALL expose req_sz  in  2  size: 00 byte, 01 word, 10 long, 11 treated as long.
REQ-008 SHALL expose req_adr  in  16  hub byte address.
REQ-009 SHALL expose req_wd  in  32  write data, right-justified.
REQ-010 SHALL expose busy  out  1  high whenever state is not IDLE.
REQ-011 SHALL expose done  out  1  one-cycle completion pulse.
REQ-012 SHALL expose rd  out  32  read result, zero-extended; valid while done is high.
REQ-013 SHALL expose err  out  1  misalignment flag, valid while done is high.
REQ-014 SHALL expose mem_w  out  1  hub write strobe.
REQ-015 SHALL expose mem_wb  out  4  hub byte-lane enables.
REQ-016 SHALL expose mem_a  out  14  hub long address.
REQ-017 SHALL expose mem_d  out  32  hub write data.
REQ-018 SHALL expose mem_q  in  32  hub read data; registered by the hub on the ena_bus edge.

Function
REQ-019 SHALL use four states: IDLE, WAIT, CAP and DONE.
REQ-020 SHALL, in IDLE with req=1, latch req_we, req_sz, req_adr and req_wd, then enter WAIT.
REQ-021 SHALL ignore req in any state other than IDLE, with no queuing.
REQ-022 SHALL hold mem_a = adr[15:2] for the whole of WAIT.
REQ-023 SHALL drive mem_wb as follows: byte = 1 shifted left by adr[1:0]; word = 1100 if adr[1] else 0011; long = 1111.
REQ-024 SHALL drive mem_d as follows: byte = wd[7:0] replicated x4; word = wd[15:0] replicated x2; long = wd.
REQ-025 SHALL drive mem_w combinationally as (state==WAIT) & we & slot_go; it is 0 in all other states.
REQ-026 SHALL move WAIT to CAP on the cycle where ena_bus & slot_go; otherwise it stays in WAIT indefinitely.
REQ-027 SHALL, in CAP, register rd from mem_q; for writes, rd becomes 0.
REQ-028 SHALL extract read data as follows: byte = mem_q >> 8*adr[1:0], masked to 8 bits; word = upper or lower half by adr[1]; long = mem_q.
REQ-029 SHALL move CAP to DONE unconditionally.
REQ-030 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-031 SHALL accept a new req on the cycle after DONE, not during DONE.
REQ-032 SHALL complete with latency slot cycle +2 cycles to done.
REQ-033 SHALL, when the slot arrives in the same cycle WAIT is entered, not use that slot; slot_go is evaluated from the first WAIT cycle.
REQ-034 SHALL hold rd and err stable from DONE until the next DONE.

Reset
REQ-035 SHALL, on reset=1, enter IDLE and clear busy, done, rd, err, mem_w, mem_wb, mem_a and mem_d to 0.
REQ-036 SHALL, on reset asserted mid-operation, abort the transfer with no done pulse.
REQ-037 SHALL never perform a write that had not yet occurred when reset was asserted.
REQ-038 SHALL let reset take priority over every other input in the same cycle.

Configuration
REQ-039 SHALL implement HUB_XFER_ALIGN_CHK_EN, which when defined rejects misaligned requests (word with adr[0]=1; long with adr[1:0]!=00).
REQ-040 SHALL, when HUB_XFER_ALIGN_CHK_EN is defined, handle a misaligned request as IDLE -> DONE directly: no WAIT, mem_w never asserted, rd=0, err=1 with done.
REQ-041 SHALL, when HUB_XFER_ALIGN_CHK_EN is undefined, tie err to 0, ignore adr[0] for word and adr[1:0] for long, and place no other logic for the check.

Verification
REQ-042 SHALL test a long write: req_we=1, sz=10, adr=0x0104, wd=0x12345678, slot_go on third ena_bus -> one mem_w pulse with mem_a=0x0041, wb=1111, d=0x12345678; done 2 cycles later.
REQ-043 SHALL test a byte read: adr=0x0106, mem_q=0xAABBCCDD -> rd=0x000000BB with done; mem_w stays 0 throughout.
REQ-044 SHALL test a word write: adr=0x0002, wd=0x0000BEEF -> wb=1100, d=0xBEEFBEEF.
REQ-045 SHALL test reset mid-WAIT: req issued, reset before slot_go -> no mem_w, no done, all outputs 0; the next req then completes normally.
REQ-046 SHALL test back-to-back requests: req held high continuously -> second transfer starts the cycle after DONE; no req is lost or duplicated.
REQ-047 SHALL test misalignment: long at adr=0x0003 -> with HUB_XFER_ALIGN_CHK_EN, done+err next cycle and no mem_w; without it, access goes to mem_a=0x0000 with err=0.
